// File: rtl/uart_resp_packer.sv
// Response packet framer for a byte-wide UART transmitter.
// Each packet is sent as: header, function code, _NUM_DATA payload bytes,
// then a checksum. The checksum is the 8-bit sum of the function code and
// the payload bytes.
module uart_resp_packer #(
  parameter int          _NUM_DATA = 11,
  parameter logic [7:0]  _HEADER   = 8'hAA
) (
  input  logic                    clk_50M,
  input  logic                    rst,
  input  logic                    send_req,
  input  logic [7:0]              send_func,
  input  logic [8*_NUM_DATA-1:0]  send_data,
  output logic                    req_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  input  logic                    tx_busy,
  output logic                    pack_sent,
  output logic                    busy
);

  localparam int NUM_BYTES = _NUM_DATA + 3;
  localparam int IDX_W     = $clog2(NUM_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
  localparam logic [IDX_W-1:0] FUNC_IDX = IDX_W'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [7:0]               func_q, func_d;
  logic [8*_NUM_DATA-1:0]   data_q, data_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [7:0]               csum_q, csum_d;
  logic [7:0]               tx_data_q, tx_data_d;
  logic [7:0]               cur_byte;
  logic                     capture;

  // State register; reset abandons any packet in flight.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: strobe a byte, wait for the transmitter to start and finish it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (send_req) state_d = START;
      START:   if (!tx_busy) state_d = WAIT_HI;
      WAIT_HI: if (tx_busy)  state_d = WAIT_LO;
      WAIT_LO: if (!tx_busy) state_d = (idx_q == LAST_IDX) ? DONE : START;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: the strobe is combinational so the first byte can leave one cycle after capture.
  always_comb begin
    req_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    tx_start  = (state_q == START) && !tx_busy;
    pack_sent = (state_q == DONE);
    tx_data   = tx_start ? cur_byte : tx_data_q;
  end

  // Select the byte for the current index from the latched request.
  always_comb begin
    cur_byte = _HEADER;
    if (idx_q == FUNC_IDX) begin
      cur_byte = func_q;
    end else if (idx_q == LAST_IDX) begin
      cur_byte = csum_q;
    end else begin
      for (int i = 0; i < _NUM_DATA; i++) begin
        if (idx_q == IDX_W'(i + 2)) cur_byte = data_q[8*i +: 8];
      end
    end
  end

  // Datapath updates: latch the request, accumulate checksum per strobe, advance the index.
  always_comb begin
    capture   = (state_q == IDLE) && send_req;
    func_d    = func_q;
    data_d    = data_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    tx_data_d = tx_data_q;
    if (capture) begin
      func_d = send_func;
      data_d = send_data;
      idx_d  = '0;
      csum_d = 8'h00;
    end
    if (tx_start) begin
      tx_data_d = cur_byte;
      if (idx_q != '0 && idx_q != LAST_IDX) csum_d = csum_q + cur_byte;
    end
    if ((state_q == WAIT_LO) && !tx_busy && (idx_q != LAST_IDX)) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      func_q    <= 8'h00;
      data_q    <= '0;
      idx_q     <= '0;
      csum_q    <= 8'h00;
      tx_data_q <= 8'h00;
    end else begin
      func_q    <= func_d;
      data_q    <= data_d;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
      tx_data_q <= tx_data_d;
    end
  end

endmodule

// File: doc/uart_resp_packer.md
UART_RESP_PACKER -- requirements
Module: uart_resp_packer

Interface
REQ-001 SHALL have parameter _NUM_DATA, default 11, payload bytes per packet (1..11).
REQ-002 SHALL have parameter _HEADER, default 8'hAA, first byte of every packet.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk_50M  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port send_req  input  1  request to send one packet; sampled only when req_ready=1.
REQ-007 SHALL have port send_func  input  8  function code, mirrors receive-side func_reg.
REQ-008 SHALL have port send_data  input  8*_NUM_DATA  payload; data1 = [7:0], dataN = [8N-1:8N-8].
REQ-009 SHALL have port req_ready  output  1  high only in IDLE.
REQ-010 SHALL have port tx_data  output  8  byte presented to the UART transmitter.
REQ-011 SHALL have port tx_start  output  1  single-cycle strobe; tx_data valid in the same cycle.
REQ-012 SHALL have port tx_busy  input  1  UART transmitter busy flag.
REQ-013 SHALL have port pack_sent  output  1  single-cycle pulse when the last byte has finished transmission.
REQ-014 SHALL have port busy  output  1  high from request capture until the pack_sent cycle, inclusive.

Function
REQ-015 Packet order SHALL be: _HEADER, send_func, data1..data_NUM_DATA, checksum (total _NUM_DATA+3 bytes).
REQ-016 Checksum SHALL be the 8-bit sum modulo 256 of send_func and all payload bytes; header excluded.
REQ-017 On a clock edge with send_req=1 and req_ready=1, send_func and send_data SHALL be latched, the byte index cleared, and the FSM SHALL move IDLE->START.
REQ-018 FSM states SHALL be IDLE, START, WAIT_HI, WAIT_LO, DONE.
REQ-019 START: when tx_busy=0, assert tx_start for exactly one cycle with the indexed byte on tx_data, then go to WAIT_HI; when tx_busy=1, hold without strobing.
REQ-020 WAIT_HI SHALL remain until tx_busy=1, then go to WAIT_LO.
REQ-021 WAIT_LO SHALL remain until tx_busy=0; then, if the byte was the checksum, go to DONE; otherwise increment the index and go to START.
REQ-022 DONE SHALL assert pack_sent for one cycle and return to IDLE; req_ready SHALL be high on the following cycle.
REQ-023 tx_data SHALL hold the last sent byte between strobes; it SHALL change only in the tx_start cycle.
REQ-024 The checksum SHALL be accumulated as each byte is strobed; it SHALL be complete before the checksum byte's START.
REQ-025 send_req while busy=1 SHALL be ignored, without queuing; input changes after capture SHALL NOT affect the packet in flight.
REQ-026 The byte index SHALL be wide enough for _NUM_DATA+3 values and SHALL never wrap within a packet.
REQ-027 The minimum request-to-first-tx_start latency SHALL be 1 cycle, provided tx_busy=0.

Reset
REQ-028 While rst=1, all outputs SHALL be: state IDLE, req_ready=1, tx_data=8'h00, tx_start=0, pack_sent=0, busy=0; the checksum and index SHALL be 0.
REQ-029 Assertion of rst mid-packet SHALL abandon the packet immediately; no further tx_start SHALL occur until a new request.
REQ-030 After rst deasserts, the first edge SHALL accept send_req if present.

Verification
REQ-031 Basic packet: func=8'h01, data1..11=8'h01..8'h0B, transmitter model busy 10 cycles per byte -> 14 strobes AA 01 01 02 03 04 05 06 07 08 09 0A 0B 43, then one pack_sent pulse.
REQ-032 Checksum wrap: func=8'hFF, all data=8'hFF -> checksum 8'hF4 (12*255 mod 256).
REQ-033 Busy-at-start: tx_busy held 1 for 5 cycles at request -> no tx_start until tx_busy=0; first strobe carries 8'hAA.
REQ-034 Request while busy: second send_req mid-packet with func=8'h02 -> ignored; exactly one packet is sent, and req_ready=0 until after pack_sent.
REQ-035 Mid-packet reset: rst pulsed after 5th strobe -> outputs at reset values; new request sends a full packet starting 8'hAA.
REQ-036 Back-to-back: send_req held high continuously -> a new packet starts on the cycle after pack_sent, with no lost or duplicated bytes.
